dual_nibble_monitor: RTL

DUAL_NIBBLE_MONITOR -- requirements
Module: dual_nibble_monitor

---
 rtl/dual_nibble_monitor_pkg.sv | 22 ++
 rtl/dual_nibble_monitor_if.sv | 19 +
 rtl/dual_nibble_monitor_fifo.sv | 47 ++++
 rtl/dual_nibble_monitor.sv | 96 +++++++++
 4 files changed

// File: rtl/dual_nibble_monitor_pkg.sv
// Shared types and default sizes for the dual nibble monitor.
package nibble_mon_pkg;

  localparam int DEF_DW    = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TSW   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Event record at default widths; the FIFO stores the same field order flat.
  typedef struct packed {
    logic [DEF_TSW-1:0] stamp;
    logic [DEF_DW-1:0]  v1;
    logic [DEF_DW-1:0]  v2;
    logic [1:0]         chg;
  } evt_t;

endpackage

// File: rtl/dual_nibble_monitor_if.sv
// Event output stream: valid/ready handshake plus the head event fields.
interface dual_nibble_monitor_if
  import nibble_mon_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int TSW = DEF_TSW
);
  logic           evt_valid;
  logic           evt_ready;
  logic [TSW-1:0] evt_stamp;
  logic [DW-1:0]  evt_v1;
  logic [DW-1:0]  evt_v2;
  logic [1:0]     evt_chg;

  modport master (output evt_valid, evt_stamp, evt_v1, evt_v2, evt_chg,
                  input  evt_ready);
  modport slave  (input  evt_valid, evt_stamp, evt_v1, evt_v2, evt_chg,
                  output evt_ready);
endinterface

// File: rtl/dual_nibble_monitor_fifo.sv
// Show-ahead FIFO: head word is visible on dout while not empty.
// A push into a full FIFO is taken only if a pop happens the same cycle.
module evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally (DEPTH is a power of two); level tracks pushes minus pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dual_nibble_monitor.sv
// Watches two values, queues a timestamped record whenever either changes,
// and counts records lost to a full queue.
module dual_nibble_monitor
  import nibble_mon_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TSW   = DEF_TSW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [DW-1:0]          v1_i,
  input  logic [DW-1:0]          v2_i,
  dual_nibble_monitor_if.master  evt,
  output logic                   ovf,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] level
);
  localparam int EW = TSW + 2*DW + 2;

  state_e         state;
  logic [TSW-1:0] ts;
  logic [DW-1:0]  prev1, prev2;
  logic [1:0]     chg;
  logic           push, pop, full, empty, drop;
  logic [EW-1:0]  din, dout;

  // Free-running timestamp, unaffected by en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  // PRIME captures a baseline so the first enabled cycle never reports a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prev1 <= '0;
      prev2 <= '0;
    end else begin
      case (state)
        IDLE:    if (en) state <= PRIME;
        PRIME, RUN: begin
          if (!en) state <= IDLE;
          else begin
            state <= RUN;
            prev1 <= v1_i;
            prev2 <= v2_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Change detection and queue handshake.
  always_comb begin
    chg  = {v2_i != prev2, v1_i != prev1};
    push = (state == RUN) && en && (chg != 2'b00);
    pop  = evt.evt_valid && evt.evt_ready;
    drop = push && full && !pop;
    din  = {ts, v1_i, v2_i, chg};
  end

  // Sticky overflow and saturating drop count; clr wins over a same-cycle drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  evt_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign evt.evt_valid = !empty;
  assign {evt.evt_stamp, evt.evt_v1, evt.evt_v2, evt.evt_chg} = dout;

endmodule
